// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcode encodings, instruction field positions and
// the fetch-buffer entry/state types used by the fetch front end.
package mips32_pkg;

   localparam int INSTR_W = 32;
   localparam int OPC_HI  = 31;
   localparam int OPC_LO  = 26;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_AND   = 6'b000010;
   localparam logic [5:0] OP_OR    = 6'b000011;
   localparam logic [5:0] OP_SLT   = 6'b000100;
   localparam logic [5:0] OP_MUL   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b001000;
   localparam logic [5:0] OP_SW    = 6'b001001;
   localparam logic [5:0] OP_ADDI  = 6'b001010;
   localparam logic [5:0] OP_SUBI  = 6'b001011;
   localparam logic [5:0] OP_SLTI  = 6'b001100;
   localparam logic [5:0] OP_BNEQZ = 6'b001101;
   localparam logic [5:0] OP_BEQZ  = 6'b001110;
   localparam logic [5:0] OP_HLT   = 6'b111111;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0]        npc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic isHalt(input logic [INSTR_W-1:0] instr);
      return instr[OPC_HI:OPC_LO] == OP_HLT;
   endfunction

endpackage

// File: rtl/mips32_fetch_buffer_if.sv
// Fetch-buffer bus bundle: instruction-memory req/ack side, decode valid/ready
// side, branch redirect and status. master = fetch buffer, slave = environment.
interface mips32_fetch_buffer_if #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
);
   import mips32_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic                imem_ack;
   logic [INSTR_W-1:0]  imem_rdata;
   logic                id_valid;
   logic                id_ready;
   logic [INSTR_W-1:0]  id_instr;
   logic [31:0]         id_npc;
   logic                redirect;
   logic [31:0]         redirect_pc;
   logic                halted;
   logic [CNT_W-1:0]    occupancy;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_npc, halted, occupancy,
      input  imem_ack, imem_rdata, id_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_npc, halted, occupancy,
      output imem_ack, imem_rdata, id_ready, redirect, redirect_pc
   );

endinterface

// File: rtl/mips32_fetch_buffer_fetch_fifo.sv
// Synchronous DEPTH-entry prefetch FIFO of {npc, instr} with flush; the head
// reads as zero whenever the FIFO is empty.
module fetch_fifo
   import mips32_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  fetch_entry_t                 data_i,
   output fetch_entry_t                 data_o,
   output logic                         valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [$clog2(DEPTH+1)-1:0]   countNext_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               pushEff, popEff;

   // A push into a full FIFO is only accepted when the head leaves that same cycle.
   assign valid_o     = (count_q != '0);
   assign popEff      = pop_i && valid_o;
   assign pushEff     = push_i && ((count_q != CNT_W'(DEPTH)) || popEff);
   assign count_d     = flush_i ? '0 : count_q + CNT_W'(pushEff) - CNT_W'(popEff);
   assign count_o     = count_q;
   assign countNext_o = count_d;
   assign data_o      = valid_o ? mem_q[rdPtr_q] : '0;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushEff) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (popEff)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (pushEff && !flush_i) mem_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/mips32_fetch_buffer.sv
// Instruction-fetch front end: issues word reads to instruction memory, buffers
// {instr, npc} for decode, follows taken-branch redirects and stops after HLT.
module mips32_fetch_buffer
   import mips32_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 10,
   parameter int unsigned RESET_PC = 0
) (
   input  logic                   clk1,
   input  logic                   rst_n,
   mips32_fetch_buffer_if.master  bus
);

   localparam int                CNT_W      = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

   fetch_state_e       state_q;
   logic               req_q, halted_q;
   logic [ADDR_W-1:0]  addr_q, target_q;
   logic [ADDR_W-1:0]  addrInc, redirAddr;
   logic               ackEdge, pushEn, popEn, headValid;
   logic [CNT_W-1:0]   count, countNext;
   fetch_entry_t       pushEntry, headEntry;

   assign redirAddr = bus.redirect_pc[ADDR_W-1:0];
   assign addrInc   = addr_q + ADDR_W'(1);
   assign ackEdge   = req_q && bus.imem_ack;
   assign pushEn    = ackEdge && (state_q == RUN) && !bus.redirect;
   assign popEn     = headValid && bus.id_ready;
   assign pushEntry = '{npc: 32'(addrInc), instr: bus.imem_rdata};

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk1),
      .rst_ni      (rst_n),
      .push_i      (pushEn),
      .pop_i       (popEn),
      .flush_i     (bus.redirect),
      .data_i      (pushEntry),
      .data_o      (headEntry),
      .valid_o     (headValid),
      .count_o     (count),
      .countNext_o (countNext)
   );

   // addr_q is the outstanding request address while req_q=1, otherwise the next
   // word to fetch; target_q parks a redirect until the in-flight ack returns.
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         state_q  <= RUN;
         req_q    <= 1'b0;
         addr_q   <= RESET_ADDR;
         target_q <= '0;
         halted_q <= 1'b0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (bus.redirect) begin
                  halted_q <= 1'b0;
                  if (req_q && !bus.imem_ack) begin
                     target_q <= redirAddr;
                     state_q  <= DRAIN;
                  end else begin
                     addr_q <= redirAddr;
                     req_q  <= 1'b1;
                  end
               end else if (req_q) begin
                  if (bus.imem_ack) begin
                     addr_q <= addrInc;
                     if (isHalt(bus.imem_rdata)) begin
                        req_q    <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                     end else begin
                        req_q <= (countNext < FULL_CNT);
                     end
                  end
               end else begin
                  req_q <= (countNext < FULL_CNT);
               end
            end
            DRAIN: begin
               if (bus.imem_ack) begin
                  addr_q  <= bus.redirect ? redirAddr : target_q;
                  req_q   <= 1'b1;
                  state_q <= RUN;
               end else if (bus.redirect) begin
                  target_q <= redirAddr;
               end
            end
            HALT: begin
               if (bus.redirect) begin
                  halted_q <= 1'b0;
                  addr_q   <= redirAddr;
                  req_q    <= 1'b1;
                  state_q  <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign bus.imem_req  = req_q;
   assign bus.imem_addr = addr_q;
   assign bus.id_valid  = headValid;
   assign bus.id_instr  = headEntry.instr;
   assign bus.id_npc    = headEntry.npc;
   assign bus.halted    = halted_q;
   assign bus.occupancy = count;

endmodule

// File: tb/tb_mips32_fetch_buffer.sv
// Directed bench for mips32_fetch_buffer: stall table plus hand-written
// sequences for HLT, redirect/drain, same-cycle flush and wrap/reset.
module tb_mips32_fetch_buffer;
   import mips32_pkg::*;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;

   typedef struct {
      logic              ready;
      logic              expReq;
      logic [ADDR_W-1:0] expAddr;
      int                expOcc;
      logic [31:0]       expInstr;
      logic [31:0]       expNpc;
   } stallVec_t;

   logic        clk1 = 1'b0;
   logic        rst_n, rst2_n;
   int          checks = 0;
   int          errors = 0;
   int          memLat = 0;
   int          waitCnt = 0;
   int          phase = 0;
   logic        sawAddr8 = 1'b0;
   logic [31:0] mem [1024];
   stallVec_t   vecs [9];

   mips32_fetch_buffer_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus1 ();
   mips32_fetch_buffer_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus2 ();

   mips32_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(0)) dut (
      .clk1  (clk1),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   mips32_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(1023)) dut2 (
      .clk1  (clk1),
      .rst_n (rst2_n),
      .bus   (bus2)
   );

   always #5 clk1 = ~clk1;

   // Memory for dut acks after memLat idle cycles; dut2 sees a zero-wait memory.
   always @(negedge clk1) begin
      if (bus1.imem_req) begin
         if (phase == 1 && bus1.imem_addr == 10'd8) sawAddr8 = 1'b1;
         if (waitCnt >= memLat) begin
            bus1.imem_ack   = 1'b1;
            bus1.imem_rdata = mem[bus1.imem_addr];
            waitCnt         = 0;
         end else begin
            bus1.imem_ack = 1'b0;
            waitCnt++;
         end
      end else begin
         bus1.imem_ack = 1'b0;
         waitCnt       = 0;
      end
      bus2.imem_ack   = bus2.imem_req;
      bus2.imem_rdata = mem[bus2.imem_addr];
   end

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] pc);
      bus1.id_ready    = ready;
      bus1.redirect    = redir;
      bus1.redirect_pc = pc;
      tick();
   endtask

   task automatic resetDut(input int lat);
      rst_n            = 1'b0;
      memLat           = lat;
      bus1.id_ready    = 1'b0;
      bus1.redirect    = 1'b0;
      bus1.redirect_pc = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   got;
      logic found;

      rst_n            = 1'b0;
      rst2_n           = 1'b0;
      bus2.id_ready    = 1'b0;
      bus2.redirect    = 1'b0;
      bus2.redirect_pc = '0;
      for (int i = 0; i < 1024; i++) mem[i] = {6'b010000, 26'(i)};
      mem[0]    = 32'h2801000a;
      mem[1]    = 32'h28020014;
      mem[2]    = 32'h28030019;
      mem[3]    = 32'h0ce73800;
      mem[4]    = 32'h0c631800;
      mem[5]    = 32'h00222000;
      mem[6]    = 32'h0c421000;
      mem[7]    = 32'hfc000000;
      mem[1023] = 32'h0c842000;

      vecs[0] = '{1'b0, 1'b1, 10'd0, 0, 32'h0,  32'd0};
      vecs[1] = '{1'b0, 1'b1, 10'd1, 1, mem[0], 32'd1};
      vecs[2] = '{1'b0, 1'b1, 10'd2, 2, mem[0], 32'd1};
      vecs[3] = '{1'b0, 1'b1, 10'd3, 3, mem[0], 32'd1};
      vecs[4] = '{1'b0, 1'b0, 10'd4, 4, mem[0], 32'd1};
      vecs[5] = '{1'b0, 1'b0, 10'd4, 4, mem[0], 32'd1};
      vecs[6] = '{1'b1, 1'b1, 10'd4, 3, mem[1], 32'd2};
      vecs[7] = '{1'b0, 1'b0, 10'd5, 4, mem[1], 32'd2};
      vecs[8] = '{1'b0, 1'b0, 10'd5, 4, mem[1], 32'd2};

      // Test 1: program runs to HLT with decode always ready.
      phase = 1;
      resetDut(0);
      checkOutput("reset imem_req", bus1.imem_req, 0);
      checkOutput("reset imem_addr", bus1.imem_addr, 0);
      checkOutput("reset id_valid", bus1.id_valid, 0);
      checkOutput("reset id_instr", bus1.id_instr, 0);
      checkOutput("reset id_npc", bus1.id_npc, 0);
      checkOutput("reset halted", bus1.halted, 0);
      checkOutput("reset occupancy", bus1.occupancy, 0);
      bus1.id_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 40 && got < 8; i++) begin
         tick();
         if (bus1.id_valid) begin
            checkOutput($sformatf("t1 instr[%0d]", got), bus1.id_instr, mem[got]);
            checkOutput($sformatf("t1 npc[%0d]", got), bus1.id_npc, 32'(got + 1));
            checkOutput($sformatf("t1 halted[%0d]", got), bus1.halted, (got == 7) ? 1 : 0);
            got++;
         end
      end
      checkOutput("t1 delivered count", got, 8);
      repeat (3) tick();
      checkOutput("t1 req idle after HLT", bus1.imem_req, 0);
      checkOutput("t1 halted held", bus1.halted, 1);
      checkOutput("t1 addr 8 never requested", sawAddr8, 0);
      phase = 0;

      // Test 5: redirect out of HALT restarts fetch at 0.
      applyStimulus(1'b1, 1'b1, 32'd0);
      checkOutput("t5 halted cleared", bus1.halted, 0);
      checkOutput("t5 imem_req", bus1.imem_req, 1);
      checkOutput("t5 imem_addr", bus1.imem_addr, 0);
      bus1.redirect = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (bus1.id_valid) found = 1'b1;
      end
      checkOutput("t5 refetch valid", found, 1);
      checkOutput("t5 instr", bus1.id_instr, mem[0]);
      checkOutput("t5 npc", bus1.id_npc, 1);

      // Test 2: decode stalled, FIFO fills, one pop frees exactly one request.
      resetDut(0);
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].ready, 1'b0, 32'd0);
         checkOutput($sformatf("t2[%0d] imem_req", i), bus1.imem_req, vecs[i].expReq);
         checkOutput($sformatf("t2[%0d] imem_addr", i), bus1.imem_addr, vecs[i].expAddr);
         checkOutput($sformatf("t2[%0d] occupancy", i), bus1.occupancy, vecs[i].expOcc);
         checkOutput($sformatf("t2[%0d] id_valid", i), bus1.id_valid, (vecs[i].expOcc != 0) ? 1 : 0);
         checkOutput($sformatf("t2[%0d] id_instr", i), bus1.id_instr, vecs[i].expInstr);
         checkOutput($sformatf("t2[%0d] id_npc", i), bus1.id_npc, vecs[i].expNpc);
      end

      // Test 3: redirect while addr 2 is in flight drains the stale ack.
      resetDut(3);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (bus1.imem_req && bus1.imem_addr == 10'd2) found = 1'b1;
      end
      checkOutput("t3 req to addr 2", found, 1);
      tick();
      applyStimulus(1'b0, 1'b1, 32'd5);
      checkOutput("t3 drain req held", bus1.imem_req, 1);
      checkOutput("t3 drain addr held", bus1.imem_addr, 2);
      checkOutput("t3 flushed occupancy", bus1.occupancy, 0);
      bus1.redirect = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (bus1.imem_addr != 10'd2) found = 1'b1;
      end
      checkOutput("t3 addr left 2", found, 1);
      checkOutput("t3 new addr", bus1.imem_addr, 5);
      checkOutput("t3 new req", bus1.imem_req, 1);
      checkOutput("t3 stale data dropped", bus1.occupancy, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (bus1.id_valid) found = 1'b1;
      end
      checkOutput("t3 target delivered", found, 1);
      checkOutput("t3 instr", bus1.id_instr, mem[5]);
      checkOutput("t3 npc", bus1.id_npc, 6);

      // Test 4: redirect, ack and pop all in one cycle at occupancy 3.
      resetDut(0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (bus1.occupancy == 3) found = 1'b1;
      end
      checkOutput("t4 occupancy reached 3", found, 1);
      applyStimulus(1'b1, 1'b1, 32'd9);
      checkOutput("t4 occupancy flushed", bus1.occupancy, 0);
      checkOutput("t4 id_valid", bus1.id_valid, 0);
      checkOutput("t4 acked word hidden", (bus1.id_instr == mem[3]) ? 1 : 0, 0);
      checkOutput("t4 req", bus1.imem_req, 1);
      checkOutput("t4 addr", bus1.imem_addr, 9);
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("t4 occupancy after refetch", bus1.occupancy, 1);
      checkOutput("t4 instr", bus1.id_instr, mem[9]);
      checkOutput("t4 npc", bus1.id_npc, 10);

      // Test 6: RESET_PC=1023 wraps to 0, then reset lands mid-request.
      rst2_n = 1'b1;
      tick();
      checkOutput("t6 first addr", bus2.imem_addr, 1023);
      checkOutput("t6 first req", bus2.imem_req, 1);
      tick();
      checkOutput("t6 wrapped addr", bus2.imem_addr, 0);
      checkOutput("t6 instr 1023", bus2.id_instr, mem[1023]);
      checkOutput("t6 npc of 1023", bus2.id_npc, 0);
      tick();
      checkOutput("t6 occupancy 2", bus2.occupancy, 2);
      checkOutput("t6 mid-request", bus2.imem_req, 1);
      rst2_n = 1'b0;
      tick();
      checkOutput("t6 reset req", bus2.imem_req, 0);
      checkOutput("t6 reset addr", bus2.imem_addr, 1023);
      checkOutput("t6 reset valid", bus2.id_valid, 0);
      checkOutput("t6 reset instr", bus2.id_instr, 0);
      checkOutput("t6 reset npc", bus2.id_npc, 0);
      checkOutput("t6 reset halted", bus2.halted, 0);
      checkOutput("t6 reset occupancy", bus2.occupancy, 0);
      rst2_n = 1'b1;
      tick();
      checkOutput("t6 refetch req", bus2.imem_req, 1);
      checkOutput("t6 refetch addr", bus2.imem_addr, 1023);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
